reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp_pkg.sv | 14 +
 rtl/reg_file_mp_rdport.sv | 41 ++++
 rtl/reg_file_mp.sv | 114 +++++++++++
 tb/tb_reg_file_mp.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and FSM state type for the multi-port register file.
// Optional same-cycle write bypass is enabled by defining REG_FILE_MP_BYPASS_EN.
package reg_file_mp_pkg;

   localparam int DW_DEF  = 32;
   localparam int AW_DEF  = 5;
   localparam int NRD_DEF = 2;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

endpackage

// File: rtl/reg_file_mp_rdport.sv
// One combinational read port: array mux, address-0 forcing, not-ready forcing
// and, when REG_FILE_MP_BYPASS_EN is defined, forwarding of same-cycle write data.
module reg_file_mp_rdport
   import reg_file_mp_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          ready_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] mem_i [2**AW],
   input  logic          we0_i,
   input  logic [AW-1:0] wa0_i,
   input  logic [DW-1:0] wd0_i,
   input  logic          we1_i,
   input  logic [AW-1:0] wa1_i,
   input  logic [DW-1:0] wd1_i,
   output logic [DW-1:0] data_o
);

`ifdef REG_FILE_MP_BYPASS_EN
   localparam logic BYPASS = 1'b1;
`else
   localparam logic BYPASS = 1'b0;
`endif

   // Port 1 is checked first so that it wins when both writers hit the read address.
   always_comb begin
      data_o = {DW{1'b0}};
      if (!ready_i || (addr_i == {AW{1'b0}})) begin
         data_o = {DW{1'b0}};
      end else if (BYPASS && we1_i && (wa1_i == addr_i)) begin
         data_o = wd1_i;
      end else if (BYPASS && we0_i && (wa0_i == addr_i)) begin
         data_o = wd0_i;
      end else begin
         data_o = mem_i[addr_i];
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read, dual-write register file with hardware clear walk after reset.
// Define REG_FILE_MP_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int DW  = DW_DEF,
   parameter int AW  = AW_DEF,
   parameter int NRD = NRD_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD*DW-1:0] rd_data,
   input  logic              we0,
   input  logic [AW-1:0]     wa0,
   input  logic [DW-1:0]     wd0,
   input  logic              we1,
   input  logic [AW-1:0]     wa1,
   input  logic [DW-1:0]     wd1,
   output logic              ready,
   output logic              collide
);

   localparam int            DEPTH    = 2**AW;
   localparam logic [AW-1:0] ADDR_0   = {AW{1'b0}};
   localparam logic [AW-1:0] ADDR_1   = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] ADDR_TOP = {AW{1'b1}};

   state_e          state_q;
   logic [AW-1:0]   clr_ptr_q;
   logic            ready_q;
   logic            collide_q;
   logic [DW-1:0]   mem_q [DEPTH];

   logic            wr0_en_d;
   logic            wr1_en_d;
   logic            collide_d;
   logic            clear_en_d;

   // Write qualification; ready_q drops asynchronously so writes stop at once in reset.
   always_comb begin
      wr0_en_d   = ready_q & we0 & (wa0 != ADDR_0);
      wr1_en_d   = ready_q & we1 & (wa1 != ADDR_0);
      collide_d  = wr0_en_d & wr1_en_d & (wa0 == wa1);
      clear_en_d = rst_n & (state_q == CLEAR);
   end

   // Control FSM: walk clr_ptr through every non-zero entry, then run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= CLEAR;
         clr_ptr_q <= ADDR_1;
         ready_q   <= 1'b0;
         collide_q <= 1'b0;
      end else begin
         collide_q <= collide_d;
         case (state_q)
            CLEAR: begin
               if (clr_ptr_q == ADDR_TOP) begin
                  state_q <= RUN;
                  ready_q <= 1'b1;
               end else begin
                  clr_ptr_q <= clr_ptr_q + ADDR_1;
                  ready_q   <= 1'b0;
               end
            end
            RUN: begin
               ready_q <= 1'b1;
            end
            default: begin
               state_q   <= CLEAR;
               clr_ptr_q <= ADDR_1;
               ready_q   <= 1'b0;
            end
         endcase
      end
   end

   // Storage array, deliberately without reset; port 1 is written last so it wins.
   always_ff @(posedge clk) begin
      if (clear_en_d) begin
         mem_q[clr_ptr_q] <= {DW{1'b0}};
      end else begin
         if (wr0_en_d) begin
            mem_q[wa0] <= wd0;
         end
         if (wr1_en_d) begin
            mem_q[wa1] <= wd1;
         end
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      reg_file_mp_rdport #(
         .DW (DW),
         .AW (AW)
      ) u_rdport (
         .ready_i (ready_q),
         .addr_i  (rd_addr[k*AW +: AW]),
         .mem_i   (mem_q),
         .we0_i   (we0),
         .wa0_i   (wa0),
         .wd0_i   (wd0),
         .we1_i   (we1),
         .wa1_i   (wa1),
         .wd1_i   (wd1),
         .data_o  (rd_data[k*DW +: DW])
      );
   end

   assign ready   = ready_q;
   assign collide = collide_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and randomised self-checking bench for reg_file_mp (default and small
// NRD=4/DW=16/AW=3 configuration), scoreboard-driven with immediate assertions.
module tb_reg_file_mp;

   logic        clk;
   logic        rst_n;

   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic        we0, we1;
   logic [4:0]  wa0, wa1;
   logic [31:0] wd0, wd1;
   logic        ready, collide;

   logic [11:0] r_rd_addr;
   logic [63:0] r_rd_data;
   logic        r_we0, r_we1;
   logic [2:0]  r_wa0, r_wa1;
   logic [15:0] r_wd0, r_wd1;
   logic        r_ready, r_collide;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   reg_file_mp u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .we0     (we0),
      .wa0     (wa0),
      .wd0     (wd0),
      .we1     (we1),
      .wa1     (wa1),
      .wd1     (wd1),
      .ready   (ready),
      .collide (collide)
   );

   reg_file_mp #(.DW(16), .AW(3), .NRD(4)) u_dut4 (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_addr (r_rd_addr),
      .rd_data (r_rd_data),
      .we0     (r_we0),
      .wa0     (r_wa0),
      .wd0     (r_wd0),
      .we1     (r_we1),
      .wa1     (r_wa1),
      .wd1     (r_wd1),
      .ready   (r_ready),
      .collide (r_collide)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_v(input string tag, input logic [63:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic check(input logic [63:0] obs);
      exp_t e;
      total_cnt++;
      if (sb.size() == 0) begin
         $error("FAIL scoreboard_empty: observed=%0h expected=<none>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) pass_cnt++;
         else $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count edges from the current point until ready rises, bounded.
   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 100) begin
         tick();
         n++;
      end
   endtask

   logic [15:0] m [8];
   logic [15:0] e16;
   logic [2:0]  ra;
   logic        exp_col;
   int          n;

   initial begin
      rst_n = 1'b0;
      rd_addr = 10'd0; we0 = 1'b0; we1 = 1'b0;
      wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'd0; wd1 = 32'd0;
      r_rd_addr = 12'd0; r_we0 = 1'b0; r_we1 = 1'b0;
      r_wa0 = 3'd0; r_wa1 = 3'd0; r_wd0 = 16'd0; r_wd1 = 16'd0;
      for (int i = 0; i < 8; i++) m[i] = 16'd0;

      repeat (3) tick();
      expect_v("reset_ready", 64'd0);   check({63'd0, ready});
      expect_v("reset_collide", 64'd0); check({63'd0, collide});
      expect_v("reset_rd_data", 64'd0); check(rd_data);

      @(negedge clk);
      rst_n = 1'b1;
      wait_ready(n);
      expect_v("ready_edges", 64'd31); check(64'(n));

      for (int a = 0; a < 32; a++) begin
         rd_addr = {5'(31 - a), 5'(a)};
         #1;
         expect_v("init_zero", 64'd0); check(rd_data);
      end

      we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
      tick();
      we0 = 1'b0;
      rd_addr = {5'd5, 5'd5};
      #1;
      expect_v("wr5_both_ports", {32'hDEADBEEF, 32'hDEADBEEF}); check(rd_data);

      we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1;
      tick();
      we0 = 1'b0;
      rd_addr = {5'd5, 5'd0};
      #1;
      expect_v("addr0_reads_zero", {32'hDEADBEEF, 32'h0}); check(rd_data);

      we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
      we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
      tick();
      we0 = 1'b0; we1 = 1'b0;
      rd_addr = {5'd7, 5'd7};
      #1;
      expect_v("collide_pulse", 64'd1);          check({63'd0, collide});
      expect_v("port1_wins", {32'h22, 32'h22}); check(rd_data);
      tick();
      expect_v("collide_clears", 64'd0); check({63'd0, collide});

      we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h33;
      we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h44;
      tick();
      we0 = 1'b0; we1 = 1'b0;
      #1;
      expect_v("addr0_no_collide", 64'd0); check({63'd0, collide});

      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h55;
      rd_addr = {5'd0, 5'd3};
      #1;
`ifdef REG_FILE_MP_BYPASS_EN
      expect_v("same_cycle_read", {32'h0, 32'h55});
`else
      expect_v("same_cycle_read", {32'h0, 32'h0});
`endif
      check(rd_data);
      tick();
      we0 = 1'b0;
      #1;
      expect_v("after_write_edge", {32'h0, 32'h55}); check(rd_data);

      repeat (40) tick();
      rd_addr = {5'd7, 5'd5};
      #1;
      expect_v("hold_in_run", {32'h22, 32'hDEADBEEF}); check(rd_data);

      @(negedge clk);
      rst_n = 1'b0;
      #1;
      expect_v("async_ready_low", 64'd0);  check({63'd0, ready});
      expect_v("reset_read_gated", 64'd0); check(rd_data);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (9) tick();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (!ready && n < 100) begin
         tick();
         n++;
         if (n == 20) begin
            we0 = 1'b1; wa0 = 5'd2; wd0 = 32'hCAFEF00D;
            we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h12345678;
         end else if (n == 21) begin
            we0 = 1'b0; we1 = 1'b0;
            expect_v("clear_no_collide", 64'd0); check({63'd0, collide});
            rd_addr = {5'd2, 5'd2};
            expect_v("clear_read_gated", 64'd0); check(rd_data);
         end
      end
      expect_v("ready_edges_restart", 64'd31); check(64'(n));
      rd_addr = {5'd5, 5'd2};
      #1;
      expect_v("clear_write_ignored", 64'd0); check(rd_data);

      expect_v("small_ready", 64'd1); check({63'd0, r_ready});
      for (int c = 0; c < 1000; c++) begin
         r_we0 = 1'($urandom_range(0, 1));
         r_we1 = 1'($urandom_range(0, 1));
         r_wa0 = 3'($urandom_range(0, 7));
         r_wa1 = ($urandom_range(0, 3) == 0) ? r_wa0 : 3'($urandom_range(0, 7));
         r_wd0 = 16'($urandom);
         r_wd1 = 16'($urandom);
         r_rd_addr = 12'($urandom);
         #1;
         for (int k = 0; k < 4; k++) begin
            ra  = r_rd_addr[k*3 +: 3];
            e16 = (ra == 3'd0) ? 16'd0 : m[ra];
`ifdef REG_FILE_MP_BYPASS_EN
            if (ra != 3'd0 && r_we1 && r_wa1 == ra)      e16 = r_wd1;
            else if (ra != 3'd0 && r_we0 && r_wa0 == ra) e16 = r_wd0;
`endif
            expect_v($sformatf("rnd_rd%0d_c%0d", k, c), {48'd0, e16});
            check({48'd0, r_rd_data[k*16 +: 16]});
         end
         exp_col = r_we0 && r_we1 && (r_wa0 == r_wa1) && (r_wa0 != 3'd0);
         if (r_we0 && r_wa0 != 3'd0) m[r_wa0] = r_wd0;
         if (r_we1 && r_wa1 != 3'd0) m[r_wa1] = r_wd1;
         tick();
         expect_v($sformatf("rnd_collide_c%0d", c), {63'd0, exp_col});
         check({63'd0, r_collide});
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
